// File: rtl/nes_emu_pkg.sv
// Shared types and constants for the NES/SNES controller emulator.
package nes_emu_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} nes_emu_state_t;

  localparam int NES_BUTTONS  = 8;
  localparam int SNES_BUTTONS = 16;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
endpackage

// File: rtl/nes_sync_edge.sv
// Two-flop synchroniser for an asynchronous console line, with rise/fall pulses.
module nes_sync_edge
  import nes_emu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;
endmodule

// File: rtl/nes_controller_emulator.sv
// Multi-channel NES/SNES serial controller emulator driven by console latch/clock.
// Optional turbo buttons are compiled in with NES_EMU_TURBO_EN.
module nes_controller_emulator
  import nes_emu_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int NUM_BUTTONS  = NES_BUTTONS,
  parameter int ACTIVE_LOW   = 1,
  parameter int TURBO_DIV    = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      nes_latch,
  input  logic                                      nes_clock,
  input  logic [NUM_CHANNELS-1:0][NUM_BUTTONS-1:0]  buttons,
  input  logic [NUM_CHANNELS-1:0][NUM_BUTTONS-1:0]  turbo_mask,
  output logic [NUM_CHANNELS-1:0]                   nes_data,
  output logic                                      frame_strobe,
  output logic [$clog2(NUM_BUTTONS+1)-1:0]          bit_index
);
  localparam int IW = $clog2(NUM_BUTTONS+1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_BUTTONS);
  localparam logic AL_BIT = (ACTIVE_LOW != 0);

  logic latch_rise, latch_fall, clk_rise, clk_fall_unused;
  logic [NUM_CHANNELS-1:0][NUM_BUTTONS-1:0] snap;

  nes_sync_edge u_latch_sync (
    .clk_i (clk), .rst_i (reset), .d_i (nes_latch),
    .rise_o(latch_rise), .fall_o(latch_fall)
  );

  nes_sync_edge u_clock_sync (
    .clk_i (clk), .rst_i (reset), .d_i (nes_clock),
    .rise_o(clk_rise), .fall_o(clk_fall_unused)
  );

`ifdef NES_EMU_TURBO_EN
  localparam int TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  logic [TW-1:0] turbo_cnt_q;
  logic          turbo_phase_q;

  // Phase starts "pressed" and flips every TURBO_DIV frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b1;
    end else if (frame_strobe) begin
      if (turbo_cnt_q == TW'(TURBO_DIV-1)) begin
        turbo_cnt_q   <= '0;
        turbo_phase_q <= ~turbo_phase_q;
      end else begin
        turbo_cnt_q <= turbo_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    snap = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      snap[c] = buttons[c] & ~(turbo_mask[c] & {NUM_BUTTONS{~turbo_phase_q}});
  end
`else
  logic unused_turbo;
  assign unused_turbo = (^turbo_mask) ^ (TURBO_DIV > 1);
  assign snap = buttons;
`endif

  nes_emu_state_t                           state_q, state_d;
  logic [NUM_CHANNELS-1:0][NUM_BUTTONS-1:0] sr_q, sr_d;
  logic [IW-1:0]                            idx_q, idx_d;
  logic [NUM_CHANNELS-1:0]                  data_q, data_d;
  logic                                     strobe_q, strobe_d;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    if (latch_rise) begin
      state_d = LOAD;
      sr_d    = snap;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          idx_d = '0;
          if (latch_fall) begin
            state_d  = SHIFT;
            strobe_d = 1'b1;
          end else begin
            sr_d = snap;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
              sr_d[c] = {1'b0, sr_q[c][NUM_BUTTONS-1:1]};
            idx_d = idx_q + 1'b1;
            if (idx_d == IDX_MAX) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
    // Outside an active frame the line idles at the open-bus level.
    data_d = '1;
    if (state_d == LOAD || state_d == SHIFT)
      for (int c = 0; c < NUM_CHANNELS; c++)
        data_d[c] = sr_d[c][0] ^ AL_BIT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      idx_q    <= '0;
      data_q   <= '1;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  assign nes_data     = data_q;
  assign frame_strobe = strobe_q;
  assign bit_index    = idx_q;
endmodule
